bus_dev_endpoint: RTL
=====================

// Module: bus_dev_endpoint
// PURPOSE
//  Device-side terminal of the shared-bus generator/arbiter protocol (pndng/pop/D_pop, push/D_push).
//  TX path: device writes packets into a FIFO, which the arbiter drains through pndng/pop/D_pop.
//  RX path: the arbiter pushes packets through push/D_push. Packets addressed to this device
//  (or to broadcast) are buffered for the device; all others are discarded.
//  One instance per bus driver slot; the bench connects drvrs instances around the arbiter.
// PARAMETERS
//  pckg_sz      16   packet width in bits; the destination ID is D[pckg_sz-1 -: 8]
//  profundidad  8    depth of each FIFO (TX and RX), in entries; power of 2, >=2
//  id           0    this device's 8-bit bus address
//  broadcast    255  destination ID that every endpoint accepts
// PORTS
//  clk         in   1        bus clock; all logic is rising-edge
//  reset       in   1        asynchronous, active-low; clears all state
//  tx_wr       in   1        device write strobe for the TX FIFO
//  tx_data     in   pckg_sz  packet to send (destination in the top 8 bits)
//  tx_full     out  1        TX FIFO full
//  pndng       out  1        to arbiter: TX FIFO not empty
//  pop         in   1        from arbiter: consume the head of the TX FIFO
//  D_pop       out  pckg_sz  to arbiter: TX FIFO head (first-word fall-through)
//  push        in   1        from arbiter: packet valid on D_push
//  D_push      in   pckg_sz  packet delivered by the bus
//  rx_valid    out  1        RX FIFO not empty
//  rx_data     out  pckg_sz  RX FIFO head (first-word fall-through)
//  rx_rd       in   1        device read strobe; consumes rx_data
//  rx_ovf      out  1        sticky: an accepted packet was lost because the RX FIFO was full
//  rx_ovf_clr  in   1        synchronous clear of rx_ovf
// BEHAVIOUR
//  Reset (reset=0, asynchronous): both FIFOs become empty. pndng=0, D_pop=0, tx_full=0,
//   rx_valid=0, rx_data=0, rx_ovf=0. Any in-flight push, pop or write is discarded.
//  FIFO structure: circular buffer with rd/wr pointers of log2(profundidad) bits, wrapping
//   modulo profundidad, plus a count of log2(profundidad)+1 bits. D_pop and rx_data are 0
//   whenever their FIFO is empty.
//  TX write: accepted on a clk edge when tx_wr=1 and (count<profundidad or pop accepted in the
//   same cycle). A write while full with no pop is dropped silently.
//  TX pop: accepted when pop=1 and pndng=1. pop while empty is ignored (no pointer move).
//   When the FIFO is empty, a simultaneous wr and pop accept the write only, and pndng rises
//   on the next cycle.
//  Write-to-pndng latency: 1 cycle. After a pop, the next head appears on D_pop in the
//   following cycle.
//  RX filter: dest = D_push[pckg_sz-1 -: 8]. A push is accepted iff dest==id or
//   dest==broadcast; otherwise it is ignored with no state change.
//  RX write: an accepted push stores the packet if count<profundidad or rx_rd pops in the
//   same cycle. Otherwise the packet is dropped and rx_ovf is set on that edge.
//  rx_rd while empty is ignored. rx_ovf_clr has priority below a same-cycle set
//   (set wins).
//  Count update for both FIFOs: +1 on write only, -1 on read only, unchanged on both.
//  There is no state machine beyond the FIFO pointers. The bus protocol imposes no
//   backpressure: push can never be refused, only dropped.
// CONFIGURATION
//  BUS_EP_DROP_CNT_EN defined: adds output drop_cnt[7:0].
//   - Increments on every RX overflow drop and every TX write dropped while full.
//   - Saturates at 255; resets to 0; cleared by rx_ovf_clr unless a drop occurs in the
//     same cycle (then it becomes 1).
//  BUS_EP_DROP_CNT_EN undefined: no drop_cnt port and no counter logic; all other
//   behaviour is identical.
// TESTING
//  1. Reset mid-stream: with 3 entries in TX and RX, pull reset low between clock edges.
//     Required: pndng=0, rx_valid=0 and D_pop=0 immediately, without waiting for clk.
//  2. TX fill/drain (id=3): write 8 packets 0x0100..0x0107 -> tx_full=1; a 9th write is
//     dropped. Pop 8 times -> D_pop sequence 0x0100..0x0107, then pndng=0.
//  3. RX filter (id=3): push 0x0311, 0x0422, 0xFF33 -> rx_data reads 0x0311 then 0xFF33;
//     0x0422 never appears.
//  4. RX overflow: push 9 packets with dest 0x03 without rx_rd -> rx_ovf=1, 8 entries kept
//     (the first 8 in order). rx_ovf_clr -> rx_ovf=0.
//  5. Simultaneous events: TX full with wr+pop in the same cycle -> count stays 8 and the
//     new packet is last out. TX empty with wr+pop -> 1 entry, pndng=1 next cycle.
//  6. With BUS_EP_DROP_CNT_EN: 300 dropped writes -> drop_cnt=255.
//     Without the macro, the bench compiles without the drop_cnt port.

Source files
------------

// File: rtl/bus_dev_endpoint.sv
// bus_dev_endpoint: device-side terminal of the shared-bus arbiter protocol.
//   TX: device writes into a FIFO that the arbiter drains via pndng/pop/D_pop.
//   RX: arbiter pushes via push/D_push; packets for this id or broadcast are buffered.
// Latency: write-to-pndng 1 cycle; FIFO heads are first-word fall-through.
// Backpressure: none on the bus side; a push into a full RX FIFO is dropped and
//   flagged on rx_ovf. A TX write while full (with no same-cycle pop) is dropped.
// Ports:
//   clk, reset (async active-low)
//   tx_wr/tx_data/tx_full           device TX write side
//   pndng/pop/D_pop                 arbiter TX drain side
//   push/D_push                     arbiter RX delivery side
//   rx_valid/rx_data/rx_rd          device RX read side
//   rx_ovf/rx_ovf_clr               sticky RX overflow flag and its clear
//   drop_cnt                        only with BUS_EP_DROP_CNT_EN defined
// Configuration macro: BUS_EP_DROP_CNT_EN adds the saturating drop counter.

// ---------------------------------------------------------------------------
// bus_ep_fifo: circular-buffer FIFO with first-word fall-through head.
//   Latency: a write is visible at head_o / nempty_o on the next cycle.
//   Backpressure: writes while full are accepted only if a read is accepted in
//   the same cycle; otherwise they are discarded. Reads while empty are ignored.
// Ports: wr_i/wr_dat_i write request, rd_i read request, head_o FIFO head
//   (0 when empty), full_o, nempty_o.
// ---------------------------------------------------------------------------
module bus_ep_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         wr_i,
  input  logic [W-1:0] wr_dat_i,
  input  logic         rd_i,
  output logic [W-1:0] head_o,
  output logic         full_o,
  output logic         nempty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rd_acc;
  logic          wr_acc;

  assign nempty_o = (cnt_q != '0);
  assign full_o   = (cnt_q == CW'(DEPTH));

  // A read only counts when there is something to read, so an empty FIFO
  // with simultaneous wr+rd accepts just the write.
  assign rd_acc = rd_i && nempty_o;
  // A same-cycle read frees the slot a full FIFO needs for the write.
  assign wr_acc = wr_i && (!full_o || rd_acc);

  // Head is forced to zero when empty so stale storage never leaks out,
  // including immediately after an asynchronous reset.
  assign head_o = nempty_o ? mem_q[rd_ptr_q] : '0;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    // Pointers are exactly AW bits wide, so wrap modulo DEPTH is free.
    if (rd_acc) rd_ptr_d = rd_ptr_q + AW'(1);
    if (wr_acc) wr_ptr_d = wr_ptr_q + AW'(1);
    case ({wr_acc, rd_acc})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: contents are only observable through head_o,
  // which is gated by the (reset) count.
  always_ff @(posedge clk_i) begin
    if (wr_acc) mem_q[wr_ptr_q] <= wr_dat_i;
  end

endmodule

// ---------------------------------------------------------------------------
// bus_dev_endpoint top
// ---------------------------------------------------------------------------
module bus_dev_endpoint #(
  parameter int pckg_sz     = 16,
  parameter int profundidad = 8,
  parameter int id          = 0,
  parameter int broadcast   = 255
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tx_wr,
  input  logic [pckg_sz-1:0] tx_data,
  output logic               tx_full,
  output logic               pndng,
  input  logic               pop,
  output logic [pckg_sz-1:0] D_pop,
  input  logic               push,
  input  logic [pckg_sz-1:0] D_push,
  output logic               rx_valid,
  output logic [pckg_sz-1:0] rx_data,
  input  logic               rx_rd,
  output logic               rx_ovf,
  input  logic               rx_ovf_clr
`ifdef BUS_EP_DROP_CNT_EN
  ,
  output logic [7:0]         drop_cnt
`endif
);

  logic [7:0] rx_dest;
  logic       rx_hit;
  logic       rx_full;
  logic       rx_drop;
  logic       rx_ovf_q, rx_ovf_d;

  // ---------------- TX path ----------------
  bus_ep_fifo #(
    .W     (pckg_sz),
    .DEPTH (profundidad)
  ) u_tx_fifo (
    .clk_i    (clk),
    .rst_ni   (reset),
    .wr_i     (tx_wr),
    .wr_dat_i (tx_data),
    .rd_i     (pop),
    .head_o   (D_pop),
    .full_o   (tx_full),
    .nempty_o (pndng)
  );

  // ---------------- RX path ----------------
  // Destination lives in the top byte; non-matching traffic never touches state.
  assign rx_dest = D_push[pckg_sz-1 -: 8];
  assign rx_hit  = push && ((rx_dest == 8'(id)) || (rx_dest == 8'(broadcast)));

  bus_ep_fifo #(
    .W     (pckg_sz),
    .DEPTH (profundidad)
  ) u_rx_fifo (
    .clk_i    (clk),
    .rst_ni   (reset),
    .wr_i     (rx_hit),
    .wr_dat_i (D_push),
    .rd_i     (rx_rd),
    .head_o   (rx_data),
    .full_o   (rx_full),
    .nempty_o (rx_valid)
  );

  // Accepted packet lost: FIFO full and no same-cycle read to make room.
  assign rx_drop = rx_hit && rx_full && !(rx_rd && rx_valid);

  // Set beats clear when both happen on the same edge.
  always_comb begin
    rx_ovf_d = rx_ovf_q;
    if (rx_drop)         rx_ovf_d = 1'b1;
    else if (rx_ovf_clr) rx_ovf_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rx_ovf_q <= 1'b0;
    else        rx_ovf_q <= rx_ovf_d;
  end

  assign rx_ovf = rx_ovf_q;

`ifdef BUS_EP_DROP_CNT_EN
  // ---------------- Drop counter ----------------
  logic       tx_drop;
  logic [1:0] n_drop;
  logic [7:0] cnt_base;
  logic [8:0] cnt_sum;
  logic [7:0] drop_cnt_q, drop_cnt_d;

  assign tx_drop = tx_wr && tx_full && !(pop && pndng);

  // TX and RX drops can coincide, so the step is 0..2.
  assign n_drop = {1'b0, tx_drop} + {1'b0, rx_drop};

  always_comb begin
    // A clear restarts from zero but still counts this cycle's drops.
    cnt_base   = rx_ovf_clr ? 8'd0 : drop_cnt_q;
    cnt_sum    = {1'b0, cnt_base} + {7'd0, n_drop};
    drop_cnt_d = cnt_sum[8] ? 8'hFF : cnt_sum[7:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) drop_cnt_q <= 8'd0;
    else        drop_cnt_q <= drop_cnt_d;
  end

  assign drop_cnt = drop_cnt_q;
`endif

endmodule
